// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction store with a fixed-latency, in-order response path.
// Requests are looked up at acceptance, travel through a LATENCY-deep pipeline and then drain
// through a small FIFO so the fetch side can stall without losing responses.
// Optional build macro: IMEM_ADDR_CHECK_EN enables misaligned / out-of-range error responses.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam int unsigned FIFO_DEPTH = LATENCY + 1;
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          deliver;
    logic [CW-1:0] outstanding_q, outstanding_d;

    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    rsp_t          lookup;

    logic [LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    rsp_t               pipe_q [LATENCY];
    rsp_t               pipe_d [LATENCY];
    logic               pipe_out_valid;
    rsp_t               pipe_out;

    rsp_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    logic head_valid;
    rsp_t head;
    logic unused_bits;

    // Byte offset from the store base; word index sits in bits [AW+1:2].
    assign rd_word = req_addr - BASE_ADDR;
    assign wr_word = wr_addr - BASE_ADDR;
    assign rd_idx  = rd_word[AW+1:2];
    assign wr_idx  = wr_word[AW+1:2];

`ifdef IMEM_ADDR_CHECK_EN
    assign unused_bits = ^{wr_word[31:AW+2], wr_word[1:0]};
`else
    assign unused_bits = ^{wr_word[31:AW+2], wr_word[1:0], rd_word[31:AW+2], rd_word[1:0]};
`endif

    assign req_ready = reset && (outstanding_q < CW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // Loader port: writes land at the edge, so a same-edge read still sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Lookup of the word being requested this cycle.
    always_comb begin
        lookup.addr = req_addr;
`ifdef IMEM_ADDR_CHECK_EN
        lookup.err   = (rd_word[1:0] != 2'b00) || (rd_word[31:AW+2] != '0);
        lookup.instr = lookup.err ? 32'h0 : mem[rd_idx];
`else
        lookup.err   = 1'b0;
        lookup.instr = mem[rd_idx];
`endif
    end

    // Pipeline shift: stage 0 captures the lookup at the acceptance edge.
    always_comb begin
        pipe_valid_d[0] = accept;
        pipe_d[0]       = lookup;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_d[k]       = pipe_q[k-1];
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_valid_q <= pipe_valid_d;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    // Head selection: FIFO entries are older than the pipeline output, which bypasses when empty.
    always_comb begin
        pipe_out_valid = pipe_valid_q[LATENCY-1];
        pipe_out       = pipe_q[LATENCY-1];
        fifo_empty     = (count_q == '0);
        head_valid     = !fifo_empty || pipe_out_valid;
        head           = fifo_empty ? pipe_out : fifo_q[rd_ptr_q];
        deliver        = head_valid && rsp_ready;
        fifo_pop       = !fifo_empty && rsp_ready;
        fifo_push      = pipe_out_valid && !(fifo_empty && rsp_ready);
    end

    // FIFO storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_q[wr_ptr_q] <= pipe_out;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!fifo_push && fifo_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Outstanding count: accepted but not yet delivered.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !deliver) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && deliver) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // Outstanding count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Response outputs read straight from the head, forced to zero when nothing is pending.
    always_comb begin
        rsp_valid = head_valid;
        rsp_instr = head_valid ? head.instr : 32'h0;
        rsp_addr  = head_valid ? head.addr : 32'h0;
        rsp_err   = head_valid && head.err;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (default LATENCY=2, DEPTH_WORDS=4096).
module tb_imem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    imem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // One request with rsp_ready high; waits (bounded) for its response and checks it.
    task automatic fetch_one(input string tag, input logic [31:0] a, input logic [31:0] exp_instr,
                             input logic exp_err);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        for (int n = 0; n < 8 && !rsp_valid; n++) begin
            step();
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_instr"}, rsp_instr, exp_instr);
        check({tag, "_addr"}, rsp_addr, a);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int stale;

        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h3000;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 32'h0;
        wr_data   = 32'h0;

        // Reset held with a request pending.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid) stale++;
        end
        check("rel_no_rsp", 32'(stale), 32'd0);

        load(32'h3000, 32'h3C01_0000);
        load(32'h3004, 32'h3421_0001);
        load(32'h3008, 32'h1111_1111);
        load(32'h300C, 32'h2222_2222);

        // Back-to-back fetch.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h3000;
        step();
        check("b2b_early", 32'(rsp_valid), 32'd0);
        req_addr = 32'h3004;
        step();
        req_valid = 1'b0;
        check("b2b0_valid", 32'(rsp_valid), 32'd1);
        check("b2b0_instr", rsp_instr, 32'h3C01_0000);
        check("b2b0_addr", rsp_addr, 32'h3000);
        check("b2b0_err", 32'(rsp_err), 32'd0);
        step();
        check("b2b1_valid", 32'(rsp_valid), 32'd1);
        check("b2b1_instr", rsp_instr, 32'h3421_0001);
        check("b2b1_addr", rsp_addr, 32'h3004);
        check("b2b1_err", 32'(rsp_err), 32'd0);
        step();
        check("b2b_drained", 32'(rsp_valid), 32'd0);

        // Backpressure: only LATENCY+1 requests get in.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        accepted  = 0;
        req_addr  = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            if (req_ready) accepted++;
            step();
            req_addr = 32'h3000 + 32'(4 * accepted);
        end
        check("bp_accepted", 32'(accepted), 32'd3);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_hold_instr", rsp_instr, 32'h3C01_0000);
        check("bp_hold_addr", rsp_addr, 32'h3000);
        rsp_ready = 1'b1;
        step();
        check("bp_ready_rise", 32'(req_ready), 32'd1);
        check("bp1_instr", rsp_instr, 32'h3421_0001);
        check("bp1_addr", rsp_addr, 32'h3004);
        step();
        req_valid = 1'b0;
        check("bp2_instr", rsp_instr, 32'h1111_1111);
        check("bp2_addr", rsp_addr, 32'h3008);
        step();
        check("bp3_valid", 32'(rsp_valid), 32'd1);
        check("bp3_instr", rsp_instr, 32'h2222_2222);
        check("bp3_addr", rsp_addr, 32'h300C);
        step();
        check("bp_drained", 32'(rsp_valid), 32'd0);

        // Read/write collision on 0x3008.
        rsp_ready = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 32'h3008;
        wr_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h3008;
        step();
        wr_en = 1'b0;
        step();
        req_valid = 1'b0;
        check("col_old_instr", rsp_instr, 32'h1111_1111);
        check("col_old_addr", rsp_addr, 32'h3008);
        step();
        check("col_new_valid", 32'(rsp_valid), 32'd1);
        check("col_new_instr", rsp_instr, 32'hDEAD_BEEF);
        step();

`ifdef IMEM_ADDR_CHECK_EN
        fetch_one("err_misalign", 32'h3002, 32'h0, 1'b1);
        fetch_one("err_below", 32'h2FFC, 32'h0, 1'b1);
        fetch_one("err_above", 32'h7000, 32'h0, 1'b1);
`else
        fetch_one("alias", 32'h7000, 32'h3C01_0000, 1'b0);
`endif

        // Reset mid-operation with two requests in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h3000;
        step();
        req_addr = 32'h3004;
        step();
        req_valid = 1'b0;
        check("mid_valid_before", 32'(rsp_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_valid_async", 32'(rsp_valid), 32'd0);
        check("mid_instr_zero", rsp_instr, 32'h0);
        check("mid_ready_low", 32'(req_ready), 32'd0);
        step();
        step();
        reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) stale++;
        end
        check("mid_no_stale", 32'(stale), 32'd0);
        fetch_one("mid_mem_3004", 32'h3004, 32'h3421_0001, 1'b0);
        fetch_one("mid_mem_3008", 32'h3008, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch stage. It accepts word-fetch requests carrying the PC, looks up a word-addressed instruction store based at 0x3000, and returns instructions in order after a fixed latency. It sits between the PC/fetch logic (the initiator) and the IF/ID register. It buffers responses so the fetch side can stall without losing data, and it provides a loader write port for preloading the program.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit instruction words; must be a power of two.
- BASE_ADDR, 32'h0000_3000: byte address of word 0.
- LATENCY, 2: clock edges from request acceptance to response visible, counted inclusively; must be ≥1.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  32  byte address (PC).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_instr  out  32  instruction word; 0 on error.
- rsp_addr  out  32  req_addr of this response.
- rsp_err  out  1  misaligned or out-of-range fetch (only when the check is compiled in).
- wr_en  in  1  loader write strobe.
- wr_addr  in  32  loader byte address.
- wr_data  in  32  loader data.

## Operation
- Word index is (addr − BASE_ADDR) >> 2, using 32-bit unsigned subtraction.
- **Accept:** a request is accepted when req_valid & req_ready at a posedge.
- **Memory read timing:** memory is read at the acceptance edge. A same-edge wr_en to the same word is not visible to that read, so the old data is returned.
- **Pipeline:** accepted requests move through a LATENCY-stage pipeline carrying {addr, instr, err}. Each then enters an in-order output FIFO of depth LATENCY+1.
- **Output:** rsp_valid, rsp_instr, rsp_addr and rsp_err are driven from the FIFO head. They hold stable while rsp_valid & !rsp_ready.
- **Outstanding counter:** `outstanding` counts accepted-but-undelivered transactions, range 0..LATENCY+1.
  - Increments on accept.
  - Decrements on rsp_valid & rsp_ready.
  - Accept and deliver on the same edge: unchanged.
- **Flow control:** req_ready = reset deasserted & (outstanding < LATENCY+1). This makes FIFO overflow impossible. Accepting a request while the count is full is illegal and cannot occur.
- **Ordering:** responses return strictly in request order. None are dropped or duplicated.
- **Loader writes:** wr_en writes mem[((wr_addr − BASE_ADDR) >> 2) mod DEPTH_WORDS] at posedge. wr_addr[1:0] is ignored. Writes are always accepted, independent of the handshake.
- **Reset (asynchronous, active low):**
  - Clears the pipeline, FIFO and outstanding.
  - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, req_ready=0 while asserted.
  - Memory contents are not cleared.
  - Transactions in flight when reset asserts are discarded; none appear after release.

## Timing
- Request accepted at edge t: its response is visible from the cycle after edge t+LATENCY−1, provided earlier responses have drained.
  - LATENCY=1: visible the cycle after acceptance.
- Throughput with rsp_ready held at 1: one request accepted and one response delivered per cycle, with no bubbles.
- rsp_ready held low: at most LATENCY+1 requests are accepted, then req_ready falls. req_ready rises in the cycle after the first delivery edge.
- First cycle after reset release: req_ready=1, rsp_valid=0.

## Configuration
- **IMEM_ADDR_CHECK_EN defined:** rsp_err=1 and rsp_instr=0 when req_addr[1:0]≠0 or word index ≥ DEPTH_WORDS. Addresses below BASE_ADDR wrap to a large index and therefore error. Error responses still occupy a slot and obey ordering.
- **IMEM_ADDR_CHECK_EN undefined:**
  - rsp_err is tied to 0.
  - Index is taken mod DEPTH_WORDS, so out-of-range addresses alias.
  - req_addr[1:0] is ignored.

## Test plan
- **Reset:** hold reset low for 3 cycles with req_valid=1 → req_ready=0 and rsp_valid=0. After release → req_ready=1 and no response appears.
- **Back-to-back fetch:**
  - Setup: LATENCY=2, rsp_ready=1. Preload 0x3000=0x3C010000 and 0x3004=0x34210001. Request 0x3000 at edge t and 0x3004 at edge t+1.
  - Required response: rsp 0x3C010000/0x3000 visible after edge t+1, then 0x34210001/0x3004 after edge t+2, with rsp_err=0.
- **Backpressure:** rsp_ready=0, continuous requests at 0x3000, 0x3004, 0x3008, 0x300C → exactly 3 accepted and req_ready=0. Raise rsp_ready → 3 responses in order, then 0x300C is accepted.
- **Errors (IMEM_ADDR_CHECK_EN defined):** requests 0x3002, 0x2FFC and 0x7000 → each gives rsp_err=1, rsp_instr=0, rsp_addr echoed.
- **Aliasing (IMEM_ADDR_CHECK_EN undefined):** request 0x7000 → returns the word at 0x3000 with rsp_err=0.
- **Reset mid-operation:** two requests in flight and rsp_ready=0; assert reset asynchronously mid-cycle → rsp_valid falls immediately. After release → no stale responses, and preloaded memory is intact on the next fetch.
- **Read/write collision:** wr_en writes 0xDEADBEEF to 0x3008 on the same edge that a request to 0x3008 is accepted → the old value is returned. A request on the next edge → 0xDEADBEEF.
